// File: rtl/sfx_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sfx_pkg
//  Purpose  : Shared types, source indices and helpers for the sfx arbiter.
//  Revision : 1.0  initial release
// ============================================================================
package sfx_pkg;

    localparam int N_SRC     = 3;
    localparam int IDX_W     = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    // Source indices; a lower index means a higher priority.
    localparam int SRC_DEATH = 0;
    localparam int SRC_EAT   = 1;
    localparam int SRC_BGM   = 2;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PLAY = 1'b1
    } state_t;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } pri_t;

    // Lowest set index of req (highest priority), with a valid flag.
    function automatic pri_t pri_enc(input logic [N_SRC-1:0] req);
        pri_t r;
        r.valid = 1'b0;
        r.idx   = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                r.valid = 1'b1;
                r.idx   = IDX_W'(i);
            end
        end
        return r;
    endfunction

    function automatic logic [N_SRC-1:0] idx2onehot(input logic [IDX_W-1:0] idx);
        return N_SRC'(1) << idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sfx_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : sfx_arbiter_if
//  Purpose  : Bundle of sfx generator inputs, user controls and buzzer outputs.
//  Revision : 1.0  initial release
// ============================================================================
interface sfx_arbiter_if;
    import sfx_pkg::*;

    logic [N_SRC-1:0] src_beep;
    logic [N_SRC-1:0] src_busy;
    logic             mute_btn;
    logic [1:0]       vol;
    logic             buzzer;
    logic [N_SRC-1:0] grant;
    logic             muted;

    // Generator/board side
    modport master (
        output src_beep, src_busy, mute_btn, vol,
        input  buzzer, grant, muted
    );

    // Arbiter side
    modport slave (
        input  src_beep, src_busy, mute_btn, vol,
        output buzzer, grant, muted
    );
endinterface
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : btn_debounce
//  Purpose  : 2-FF synchronizer, stability counter and rising-edge pulse for
//             a raw push button.
//  Revision : 1.0  initial release
// ============================================================================
module btn_debounce #(
    parameter int DEB_CYC = 1_000_000
) (
    input  wire logic clk,
    input  wire logic rst,      // asynchronous, active-low
    input  wire logic btn_raw,
    output logic      level,
    output logic      rise
);
    localparam int             CW     = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
    localparam logic [CW-1:0]  C_LAST = CW'(DEB_CYC - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic [CW-1:0] r_cnt;
    logic          r_level;
    logic          r_rise;

    // Bring the asynchronous button into the clock domain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= btn_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Accept a new level only after it has been stable for DEB_CYC cycles;
    // rise pulses for one cycle as the accepted level goes high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
        end else begin
            r_rise <= 1'b0;
            if (r_sync2 != r_level) begin
                if (r_cnt == C_LAST) begin
                    r_cnt   <= '0;
                    r_level <= r_sync2;
                    r_rise  <= r_sync2;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign level = r_level;
    assign rise  = r_rise;
endmodule
`default_nettype wire

// File: rtl/sfx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : sfx_arbiter
//  Purpose  : Fixed-priority sound source arbiter with minimum hold time,
//             4-level PWM volume and debounced mute toggle on the buzzer pin.
//  Revision : 1.0  initial release
// ============================================================================
module sfx_arbiter
    import sfx_pkg::*;
#(
    parameter int HOLD_CYC = 2_000_000,
    parameter int DEB_CYC  = 1_000_000
) (
    input  wire logic     clk,
    input  wire logic     rst,      // asynchronous, active-low
    sfx_arbiter_if.slave  bus
);
    localparam int            HW          = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam logic [HW-1:0] C_HOLD_LOAD = HW'(HOLD_CYC - 1);

    state_t           r_state, w_state_nxt;
    logic [IDX_W-1:0] r_owner, w_owner_nxt;
    logic [HW-1:0]    r_hold,  w_hold_nxt;
    logic [N_SRC-1:0] r_grant, w_grant_nxt;
    logic [1:0]       r_pwm;
    logic             r_buzzer;
    logic             r_muted;

    pri_t             w_pri;
    logic             w_tone;
    logic             w_deb_level;
    logic             w_deb_rise;

    assign w_pri = pri_enc(bus.src_busy);

    // Arbitration state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_owner <= '0;
            r_hold  <= '0;
            r_grant <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_hold  <= w_hold_nxt;
            r_grant <= w_grant_nxt;
        end
    end

    // Next owner: new grants reload the hold counter; an owner dropping out
    // bypasses the hold check, a higher source must wait for it to expire.
    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_hold_nxt  = (r_hold != '0) ? r_hold - 1'b1 : r_hold;
        w_grant_nxt = r_grant;
        case (r_state)
            ST_IDLE: begin
                w_grant_nxt = '0;
                w_hold_nxt  = '0;
                if (w_pri.valid) begin
                    w_state_nxt = ST_PLAY;
                    w_owner_nxt = w_pri.idx;
                    w_hold_nxt  = C_HOLD_LOAD;
                    w_grant_nxt = idx2onehot(w_pri.idx);
                end
            end
            ST_PLAY: begin
                if (!bus.src_busy[r_owner]) begin
                    if (w_pri.valid) begin
                        w_owner_nxt = w_pri.idx;
                        w_hold_nxt  = C_HOLD_LOAD;
                        w_grant_nxt = idx2onehot(w_pri.idx);
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_owner_nxt = '0;
                        w_hold_nxt  = '0;
                        w_grant_nxt = '0;
                    end
                end else if ((w_pri.idx < r_owner) && (r_hold == '0)) begin
                    w_owner_nxt = w_pri.idx;
                    w_hold_nxt  = C_HOLD_LOAD;
                    w_grant_nxt = idx2onehot(w_pri.idx);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_owner_nxt = '0;
                w_hold_nxt  = '0;
                w_grant_nxt = '0;
            end
        endcase
    end

    btn_debounce #(
        .DEB_CYC (DEB_CYC)
    ) u_mute_deb (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (bus.mute_btn),
        .level   (w_deb_level),
        .rise    (w_deb_rise)
    );

    // Owner's tone, gated by the PWM phase and mute; silent when idle.
    assign w_tone = (r_state == ST_PLAY) & bus.src_beep[r_owner]
                  & (r_pwm <= bus.vol) & ~r_muted;

    // PWM phase counter, buzzer output flop and mute toggle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pwm    <= 2'd0;
            r_buzzer <= 1'b0;
            r_muted  <= 1'b0;
        end else begin
            r_pwm    <= r_pwm + 2'd1;
            r_buzzer <= w_tone;
            // rise only ever fires together with a high accepted level
            r_muted  <= r_muted ^ (w_deb_rise & w_deb_level);
        end
    end

    assign bus.buzzer = r_buzzer;
    assign bus.grant  = r_grant;
    assign bus.muted  = r_muted;
endmodule
`default_nettype wire
